param_middle_ram: RTL and testbench
===================================

# param_middle_ram

Parametrised simple dual-port RAM: the next-generation intermediate buffer for the adaptive-thresholding pipeline, holding per-pixel intermediate values (row sums, partial integrals) between passes. It adds configurable width and depth, a read enable with a valid flag, and selectable read-during-write behaviour. It also has a self-timed clear engine that zeroes the array between frames, so the host does not have to. It sits between the integral-image stage and the threshold-compare stage.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 14, address width in bits.
- DEPTH, 16384, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- RDW_NEW, 0, read-during-write to the same address:
  - 0: q returns the old word.
  - 1: q returns the word being written.
- CLEAR_VALUE, 0, word written by the clear engine (DATA_WIDTH bits).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wraddress  in  ADDR_WIDTH  write address.
- wren  in  1  write enable.
- data  in  DATA_WIDTH  write data.
- rdaddress  in  ADDR_WIDTH  read address.
- rden  in  1  read enable.
- q  out  DATA_WIDTH  registered read data.
- q_valid  out  1  q holds the result of a read accepted on the previous edge.
- clear  in  1  start clear; sampled each edge.
- busy  out  1  clear engine active.

## Operation
- Reset values while reset_n is low: q=0, q_valid=0, busy=0, state IDLE, clear counter 0. Memory contents are not reset.
- State machine has two states, IDLE and CLEAR.
  - IDLE → CLEAR: on an edge with clear=1; counter←0, busy←1.
  - In CLEAR, each edge writes mem[counter]←CLEAR_VALUE and increments counter.
  - CLEAR → IDLE: on the edge that writes address DEPTH-1; busy←0.
- Writes: in IDLE, wren=1 with wraddress<DEPTH writes data on the edge.
  - wraddress≥DEPTH: write is dropped; no aliasing, no wrap.
- Reads: in IDLE, rden=1 registers mem[rdaddress] into q on the edge, and q_valid←1.
  - rdaddress≥DEPTH: q←0, q_valid←1.
  - rden=0: q holds its previous value, q_valid←0.
- Read-during-write with rdaddress==wraddress in the same cycle follows RDW_NEW.
- While busy=1, wren and rden are ignored: no user write, q holds its value, q_valid=0.
  - clear=1 while busy is ignored; the clear does not restart.
- clear=1 and wren=1 on the same IDLE edge: clear wins and the user write is dropped.
  - rden on that same edge is still honoured; q_valid=1 on the next cycle.
- reset_n low mid-clear: aborts at once; busy=0; state IDLE. Memory is partially cleared and its contents are unspecified.
- The counter is ADDR_WIDTH+1 bits wide, so DEPTH=2^ADDR_WIDTH terminates correctly.

## Timing
- Read latency is 1 cycle: address and rden sampled at edge k, q/q_valid valid after edge k. Full throughput, one read per cycle.
- Write takes effect at the edge; a read of the same address on edge k+1 or later returns the new data in both modes.
- Clear: clear sampled at edge k → busy=1 after k. Clear writes occur at edges k+1 … k+DEPTH, and busy=0 after edge k+DEPTH. busy is high for exactly DEPTH cycles.
- The first user access is honoured at edge k+DEPTH+1.
- No combinational path from any input to any output.

## Test plan
- Fill and readback (defaults, RDW_NEW=0):
  - Write data=addr[7:0] to addresses 0..49, then read 0..49 with rden=1.
  - Required: q==addr one cycle after each address and q_valid=1 throughout; rden=0 → q_valid=0 and q unchanged.
- Read-during-write on the same address 5, with mem[5]=0x05, writing 0xA5:
  - RDW_NEW=0: q=0x05, and a read the next cycle returns 0xA5.
  - RDW_NEW=1: q=0xA5.
- Clear with DEPTH=64, CLEAR_VALUE=0xFF, after filling 0..63:
  - busy high for exactly 64 cycles.
  - A write to address 3 during busy is dropped.
  - Afterwards all 64 reads return 0xFF.
  - clear pulsed mid-clear does not extend busy.
- Out-of-range with DEPTH=100, ADDR_WIDTH=7:
  - Write 0x33 to address 120 → mem[20] unchanged.
  - Read address 120 → q=0x00, q_valid=1.
- Reset mid-clear with DEPTH=64:
  - reset_n low at clear cycle 30 → q=0, q_valid=0, busy=0 immediately, with no clock needed.
  - After release, a normal write/read of address 7 with data 0x5A works.
- Clear/write collision: clear=1, wren=1 (addr 2, 0x77), rden=1 (addr 2) on one edge.
  - Required: busy=1 and q_valid=1 with the old mem[2].
  - After the clear completes, mem[2]==CLEAR_VALUE.

Source files
------------

// File: rtl/param_middle_ram.sv
// Simple dual-port RAM with 1-cycle registered read, read-valid flag, selectable
// read-during-write behaviour and a self-timed clear engine that zeroes the array.
module param_middle_ram #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 14,
  parameter int unsigned           DEPTH       = 16384,
  parameter bit                    RDW_NEW     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  input  logic                  clear,
  output logic                  busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST    = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t              state;
  logic [ADDR_WIDTH:0] count;
  logic                wr_in_range;
  logic                rd_in_range;
  logic                user_wr;

  always_comb begin
    wr_in_range = ({1'b0, wraddress} < DEPTH_W);
    rd_in_range = ({1'b0, rdaddress} < DEPTH_W);
    // A clear request on the same edge takes priority over the user write.
    user_wr     = (state == IDLE) && wren && !clear && wr_in_range;
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[count[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
    end else if (user_wr) begin
      mem[wraddress] <= data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      q       <= '0;
      q_valid <= 1'b0;
    end else if (state == CLEAR) begin
      q_valid <= 1'b0;
      count   <= count + ONE;
      if (count == LAST) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      q_valid <= rden;
      if (rden) begin
        if (!rd_in_range) begin
          q <= '0;
        end else if (RDW_NEW && user_wr && (wraddress == rdaddress)) begin
          q <= data;
        end else begin
          q <= mem[rdaddress];
        end
      end
      if (clear) begin
        state <= CLEAR;
        count <= '0;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_middle_ram.sv
// Three RAM configurations share one stimulus stream; each is checked every cycle
// against an array-based reference model, plus directed checks on key scenarios.
module tb_param_middle_ram;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] wa = '0;
  logic [13:0] ra = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [7:0]  data = '0;
  logic        clr = 1'b0;
  logic        no_clr = 1'b0;

  logic [7:0]  q_d   [3];
  logic        qv_d  [3];
  logic        busy_d[3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // A: defaults (RDW old).  B: depth 64, RDW new, clear 0xFF.  C: depth 100, out-of-range tests.
  param_middle_ram u_a (
    .clock(clock), .reset_n(reset_n), .wraddress(wa), .wren(wren), .data(data),
    .rdaddress(ra), .rden(rden), .q(q_d[0]), .q_valid(qv_d[0]), .clear(no_clr), .busy(busy_d[0])
  );

  param_middle_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64), .RDW_NEW(1'b1), .CLEAR_VALUE(8'hFF)) u_b (
    .clock(clock), .reset_n(reset_n), .wraddress(wa[5:0]), .wren(wren), .data(data),
    .rdaddress(ra[5:0]), .rden(rden), .q(q_d[1]), .q_valid(qv_d[1]), .clear(clr), .busy(busy_d[1])
  );

  param_middle_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(100), .RDW_NEW(1'b0), .CLEAR_VALUE(8'h00)) u_c (
    .clock(clock), .reset_n(reset_n), .wraddress(wa[6:0]), .wren(wren), .data(data),
    .rdaddress(ra[6:0]), .rden(rden), .q(q_d[2]), .q_valid(qv_d[2]), .clear(no_clr), .busy(busy_d[2])
  );

  // Reference model
  int unsigned depth_m [3] = '{16384, 64, 100};
  int unsigned mask_m  [3] = '{16383, 63, 127};
  bit          rdw_m   [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0]  cv_m    [3] = '{8'h00, 8'hFF, 8'h00};
  logic [7:0]  mm      [3][16384];
  logic [7:0]  m_q     [3];
  logic        m_qv    [3];
  int unsigned left_m  [3];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = '0; m_qv[i] = 1'b0; left_m[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_qv%0d", tag, i), {7'd0, qv_d[i]}, {7'd0, m_qv[i]});
      chk($sformatf("%s_busy%0d", tag, i), {7'd0, busy_d[i]}, {7'd0, left_m[i] != 0});
      if (!$isunknown(m_q[i])) chk($sformatf("%s_q%0d", tag, i), q_d[i], m_q[i]);
    end
  endtask

  // Advance one clock edge: update the model from the current inputs, then compare.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      int unsigned aw = int'(wa) & mask_m[i];
      int unsigned ar = int'(ra) & mask_m[i];
      logic        cl = (i == 1) ? clr : 1'b0;
      logic        we = wren && !cl && (aw < depth_m[i]);
      if (left_m[i] != 0) begin
        mm[i][depth_m[i] - left_m[i]] = cv_m[i];
        left_m[i]--;
        m_qv[i] = 1'b0;
      end else begin
        m_qv[i] = rden;
        if (rden) begin
          if (ar >= depth_m[i])            m_q[i] = 8'h00;
          else if (rdw_m[i] && we && aw == ar) m_q[i] = data;
          else                              m_q[i] = mm[i][ar];
        end
        if (cl)      left_m[i] = depth_m[i];
        else if (we) mm[i][aw] = data;
      end
    end
    @(posedge clock);
    #1;
    check_all("cyc");
  endtask

  task automatic drive(input logic w, input int unsigned wad, input logic [7:0] d,
                       input logic r, input int unsigned rad, input logic c);
    wren = w; wa = 14'(wad); data = d; rden = r; ra = 14'(rad); clr = c;
  endtask

  initial begin
    int unsigned n;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16384; j++) mm[i][j] = 'x;
    model_reset();

    // Reset state
    #1;
    check_all("rst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Fill 0..49 and read back
    for (int a = 0; a < 50; a++) begin drive(1, a, 8'(a), 0, 0, 0); step(); end
    for (int a = 0; a < 50; a++) begin
      drive(0, 0, 0, 1, a, 0); step();
      chk("fill_rd", q_d[0], 8'(a));
      chk("fill_qv", {7'd0, qv_d[0]}, 8'd1);
    end
    drive(0, 0, 0, 0, 0, 0); step();
    chk("hold_q", q_d[0], 8'd49);
    chk("hold_qv", {7'd0, qv_d[0]}, 8'd0);

    // Read-during-write at address 5
    drive(1, 5, 8'hA5, 1, 5, 0); step();
    chk("rdw_old", q_d[0], 8'h05);
    chk("rdw_new", q_d[1], 8'hA5);
    drive(0, 0, 0, 1, 5, 0); step();
    chk("rdw_after", q_d[0], 8'hA5);

    // Clear on B after filling 0..63
    for (int a = 0; a < 64; a++) begin drive(1, a, 8'(a), 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 1); step();
    n = busy_d[1] ? 1 : 0;
    drive(1, 3, 8'h99, 0, 0, 0); step();
    if (busy_d[1]) n++;
    drive(0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 200 && busy_d[1] === 1'b1; g++) begin
      clr = (n == 20);
      step();
      if (busy_d[1]) n++;
    end
    clr = 1'b0;
    chk("busy_len", 8'(n), 8'd64);
    for (int a = 0; a < 64; a++) begin
      drive(0, 0, 0, 1, a, 0); step();
      chk("clr_rd", q_d[1], 8'hFF);
    end

    // Out-of-range on C (depth 100)
    drive(1, 120, 8'h33, 0, 0, 0); step();
    drive(0, 0, 0, 1, 20, 0); step();
    chk("oor_wr", q_d[2], 8'd20);
    drive(0, 0, 0, 1, 120, 0); step();
    chk("oor_rd_q", q_d[2], 8'h00);
    chk("oor_rd_qv", {7'd0, qv_d[2]}, 8'd1);

    // Reset in the middle of a clear
    drive(0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (29) step();
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int j = 0; j < 64; j++) mm[1][j] = 'x;
    check_all("rst_mid");
    chk("rst_mid_busy", {7'd0, busy_d[1]}, 8'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1, 7, 8'h5A, 0, 0, 0); step();
    drive(0, 0, 0, 1, 7, 0); step();
    chk("post_rst", q_d[1], 8'h5A);

    // Clear/write collision on B
    drive(1, 2, 8'h11, 0, 0, 0); step();
    drive(1, 2, 8'h77, 1, 2, 1); step();
    chk("col_q", q_d[1], 8'h11);
    chk("col_qv", {7'd0, qv_d[1]}, 8'd1);
    chk("col_busy", {7'd0, busy_d[1]}, 8'd1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (64) step();
    drive(0, 0, 0, 1, 2, 0); step();
    chk("col_after", q_d[1], 8'hFF);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), $urandom_range(127), 8'($urandom), 1'($urandom), $urandom_range(127), 1'b0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
